// File: rtl/token_pkg.sv
// Shared definitions for the token-drop game controller: FSM states,
// USB HID keycodes and the default board geometry.
package token_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FALL = 2'd1,
      ST_LAND = 2'd2,
      ST_FULL = 2'd3
   } state_t;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int DEF_NUM_COLS  = 7;
   localparam int DEF_NUM_ROWS  = 6;
   localparam int DEF_COL0_X    = 60;
   localparam int DEF_COL_PITCH = 80;
   localparam int DEF_TOP_Y     = 75;
   localparam int DEF_ROW_PITCH = 60;
   localparam int DEF_DROP_STEP = 15;

   // Hover X of a column, kept at the 10-bit sprite coordinate width.
   function automatic logic [9:0] col_x(input logic [2:0] col,
                                        input int        col0,
                                        input int        pitch);
      return 10'(col0) + 10'(col) * 10'(pitch);
   endfunction

endpackage

// File: rtl/col_heights.sv
// Per-column fill counters. One column can be read and one incremented per
// frame; all_full_next looks ahead through a pending increment so the
// controller can pick FULL on the same edge that lands the last token.
module col_heights
   import token_pkg::*;
#(
   parameter int NUM_COLS = DEF_NUM_COLS,
   parameter int NUM_ROWS = DEF_NUM_ROWS
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [2:0] rd_col,
   output logic [2:0] rd_height,
   input  logic       inc_en,
   input  logic [2:0] inc_col,
   output logic       all_full,
   output logic       all_full_next
);

   localparam logic [2:0] ROWS3 = 3'(NUM_ROWS);

   logic [2:0] height_q [NUM_COLS];
   logic [2:0] h_next;

   // Fill counters; a full column never counts past NUM_ROWS.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         for (int c = 0; c < NUM_COLS; c++) height_q[c] <= '0;
      end else if (inc_en && height_q[inc_col] != ROWS3) begin
         height_q[inc_col] <= height_q[inc_col] + 3'd1;
      end
   end

   assign rd_height = height_q[rd_col];

   // Full flags for the current heights and for heights after the increment.
   always_comb begin
      all_full      = 1'b1;
      all_full_next = 1'b1;
      h_next        = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         h_next = height_q[c];
         if (inc_en && inc_col == 3'(c) && height_q[c] != ROWS3) h_next = height_q[c] + 3'd1;
         if (height_q[c] != ROWS3) all_full = 1'b0;
         if (h_next != ROWS3) all_full_next = 1'b0;
      end
   end

endmodule

// File: rtl/token_drop.sv
// Token-drop game controller: A/D move the hovering token, space drops it
// into the selected column, the token falls frame by frame and lands.
//
//   state | meaning
//   IDLE  | token hovers, A/D/space accepted
//   FALL  | token descends DROP_STEP per frame toward target_y
//   LAND  | one frame, drop_valid strobe, bookkeeping on exit
//   FULL  | every column full, all keys ignored until Reset
module token_drop
   import token_pkg::*;
#(
   parameter int NUM_COLS  = DEF_NUM_COLS,
   parameter int NUM_ROWS  = DEF_NUM_ROWS,
   parameter int COL0_X    = DEF_COL0_X,
   parameter int COL_PITCH = DEF_COL_PITCH,
   parameter int TOP_Y     = DEF_TOP_Y,
   parameter int ROW_PITCH = DEF_ROW_PITCH,
   parameter int DROP_STEP = DEF_DROP_STEP
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic [9:0] TokenX,
   output logic [9:0] TokenY,
   output logic       player,
   output logic       drop_valid,
   output logic [2:0] drop_col,
   output logic [2:0] drop_row,
   output logic       busy,
   output logic       board_full
);

   localparam logic [2:0] ROWS3    = 3'(NUM_ROWS);
   localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
   localparam logic [2:0] HOME_COL = 3'd3;
   localparam logic [9:0] TOP_Y10  = 10'(TOP_Y);
   localparam logic [9:0] STEP10   = 10'(DROP_STEP);
   localparam logic [9:0] PITCHY10 = 10'(ROW_PITCH);

   state_t     state_q, state_d;
   logic [7:0] prev_key;
   logic [2:0] sel_q, sel_d;
   logic [2:0] row_q, row_d;
   logic [9:0] ty_d;
   logic       player_d;
   logic       dv_d;
   logic [2:0] dcol_d, drow_d;
   logic       inc_en;
   logic [2:0] rd_height;
   logic       all_full, all_full_next;
   logic       key_pressed;
   logic [9:0] target_y, step_raw, step_y;

   col_heights #(
      .NUM_COLS (NUM_COLS),
      .NUM_ROWS (NUM_ROWS)
   ) u_heights (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .rd_col        (sel_q),
      .rd_height     (rd_height),
      .inc_en        (inc_en),
      .inc_col       (sel_q),
      .all_full      (all_full),
      .all_full_next (all_full_next)
   );

   // A press is a new, nonzero keycode relative to last frame.
   assign key_pressed = (keycode != prev_key) && (keycode != KEY_NONE);

   // Landing Y for the target row; the min() clamp stays even though
   // ROW_PITCH is a multiple of DROP_STEP with the shipped geometry.
   assign target_y = TOP_Y10 + 10'(ROWS3 - row_q) * PITCHY10;
   assign step_raw = TokenY + STEP10;
   assign step_y   = (step_raw >= target_y) ? target_y : step_raw;

   // State and every output are registered here; keycode never reaches
   // an output without passing a flop.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         prev_key   <= KEY_NONE;
         sel_q      <= HOME_COL;
         row_q      <= '0;
         TokenX     <= col_x(HOME_COL, COL0_X, COL_PITCH);
         TokenY     <= TOP_Y10;
         player     <= 1'b0;
         drop_valid <= 1'b0;
         drop_col   <= '0;
         drop_row   <= '0;
         busy       <= 1'b0;
         board_full <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_key   <= keycode;
         sel_q      <= sel_d;
         row_q      <= row_d;
         TokenX     <= col_x(sel_d, COL0_X, COL_PITCH);
         TokenY     <= ty_d;
         player     <= player_d;
         drop_valid <= dv_d;
         drop_col   <= dcol_d;
         drop_row   <= drow_d;
         busy       <= (state_d == ST_FALL) || (state_d == ST_LAND);
         board_full <= (state_d == ST_FULL);
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      row_d    = row_q;
      ty_d     = TokenY;
      player_d = player;
      dv_d     = 1'b0;
      dcol_d   = drop_col;
      drow_d   = drop_row;
      inc_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (all_full) begin
               state_d = ST_FULL;
            end else if (key_pressed) begin
               if (keycode == KEY_A) begin
                  if (sel_q != 3'd0) sel_d = sel_q - 3'd1;
               end else if (keycode == KEY_D) begin
                  if (sel_q != LAST_COL) sel_d = sel_q + 3'd1;
               end else if (keycode == KEY_SPACE) begin
                  if (rd_height != ROWS3) begin
                     row_d   = rd_height;
                     state_d = ST_FALL;
                  end
               end
            end
         end
         ST_FALL: begin
            ty_d = step_y;
            if (step_y == target_y) begin
               state_d = ST_LAND;
               dv_d    = 1'b1;
               dcol_d  = sel_q;
               drow_d  = row_q;
            end
         end
         ST_LAND: begin
            inc_en   = 1'b1;
            player_d = ~player;
            ty_d     = TOP_Y10;
            state_d  = all_full_next ? ST_FULL : ST_IDLE;
         end
         ST_FULL: begin
            state_d = ST_FULL;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_token_drop.sv
// Randomized scoreboard bench for token_drop. A frame-level reference model
// predicts the sprite position, side to move and busy/full flags each frame
// and queues the expected landings; a separate monitor pops and checks them
// whenever drop_valid is seen.
module tb_token_drop;

   logic       frame_clk;
   logic       Reset;
   logic [7:0] keycode;
   logic [9:0] TokenX, TokenY;
   logic       player, drop_valid, busy, board_full;
   logic [2:0] drop_col, drop_row;

   int checks   = 0;
   int failures = 0;
   int n_drops  = 0;
   int last_land_y = 0;

   token_drop dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .TokenX     (TokenX),
      .TokenY     (TokenY),
      .player     (player),
      .drop_valid (drop_valid),
      .drop_col   (drop_col),
      .drop_row   (drop_row),
      .busy       (busy),
      .board_full (board_full)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   // ---------------- reference model (frame level) ----------------
   localparam int COLS = 7, ROWS = 6, X0 = 60, XP = 80, Y0 = 75, YP = 60, STEP = 15;

   int         m_sel, m_player, m_busy, m_n, m_row, m_full;
   int         m_h [COLS];
   logic [7:0] m_prev;
   int         exp_q [$];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_sel = 3; m_player = 0; m_busy = 0; m_n = 0; m_row = 0; m_full = 0;
      m_prev = 8'h00;
      for (int c = 0; c < COLS; c++) m_h[c] = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic [7:0] k);
      bit pr;
      bit all;
      pr = (k != m_prev) && (k != 8'h00);
      m_prev = k;
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_h[m_sel]++;
            m_player = 1 - m_player;
            all = 1'b1;
            for (int c = 0; c < COLS; c++) if (m_h[c] != ROWS) all = 1'b0;
            if (all) m_full = 1;
         end
      end else if (!m_full && pr) begin
         if (k == 8'h04 && m_sel > 0) m_sel--;
         else if (k == 8'h07 && m_sel < COLS - 1) m_sel++;
         else if (k == 8'h2C && m_h[m_sel] < ROWS) begin
            m_row  = m_h[m_sel];
            m_n    = (ROWS - m_row) * YP / STEP + 1;
            m_busy = m_n;
            exp_q.push_back(m_sel * 8 + m_row);
         end
      end
   endtask

   function automatic int exp_y();
      int y, tgt;
      if (m_busy == 0) return Y0;
      y   = Y0 + STEP * (m_n - m_busy);
      tgt = Y0 + (ROWS - m_row) * YP;
      return (y > tgt) ? tgt : y;
   endfunction

   task automatic check_outputs();
      chk("TokenX", int'(TokenX), X0 + m_sel * XP);
      chk("TokenY", int'(TokenY), exp_y());
      chk("player", int'(player), m_player);
      chk("busy", int'(busy), (m_busy > 0) ? 1 : 0);
      chk("board_full", int'(board_full), m_full);
   endtask

   // One frame: drive key after the falling edge, let the rising edge take
   // it, then check on the next falling edge.
   task automatic cyc(input logic [7:0] k);
      keycode = k;
      @(posedge frame_clk);
      model_step(k);
      @(negedge frame_clk);
      check_outputs();
   endtask

   task automatic do_reset();
      Reset   = 1'b0;
      keycode = 8'h00;
      model_reset();
      repeat (2) @(negedge frame_clk);
      chk("rst_TokenX", int'(TokenX), 300);
      chk("rst_TokenY", int'(TokenY), 75);
      chk("rst_player", int'(player), 0);
      chk("rst_drop_valid", int'(drop_valid), 0);
      chk("rst_drop_col", int'(drop_col), 0);
      chk("rst_drop_row", int'(drop_row), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_board_full", int'(board_full), 0);
      Reset = 1'b1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy > 0; i++) cyc(8'h00);
   endtask

   // ---------------- monitor ----------------
   always @(negedge frame_clk) begin
      if (Reset === 1'b1 && drop_valid === 1'b1) begin
         int e;
         n_drops++;
         last_land_y = int'(TokenY);
         if (exp_q.size() == 0) begin
            chk("unexpected_drop", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("drop_col", int'(drop_col), e / 8);
            chk("drop_row", int'(drop_row), e % 8);
            chk("land_y", int'(TokenY), Y0 + (ROWS - e % 8) * YP);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int d0, fall_cnt, busy_cnt, c;
      logic [7:0] k;
      Reset   = 1'b0;
      keycode = 8'h00;
      @(negedge frame_clk);

      // column moves and edge clamp
      do_reset();
      cyc(8'h07); cyc(8'h00); cyc(8'h07);
      chk("sel5_TokenX", int'(TokenX), 460);
      repeat (3) begin cyc(8'h07); cyc(8'h00); end
      chk("clamp_TokenX", int'(TokenX), 540);
      repeat (6) begin cyc(8'h04); cyc(8'h00); end
      chk("clamp0_TokenX", int'(TokenX), 60);

      // held space: exactly one drop, 24 falling frames
      do_reset();
      d0 = n_drops; fall_cnt = 0;
      repeat (30) begin
         cyc(8'h2C);
         if (busy && !drop_valid) fall_cnt++;
      end
      chk("fall_cycles", fall_cnt, 24);
      chk("held_space_drops", n_drops - d0, 1);
      chk("player_after_drop", int'(player), 1);

      // stack column 3, then refuse a seventh token
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(8'h2C); cyc(8'h00); wait_idle();
      end
      chk("row5_land_y", last_land_y, 135);
      d0 = n_drops; busy_cnt = 0;
      cyc(8'h2C);
      repeat (10) begin cyc(8'h00); if (busy) busy_cnt++; end
      chk("full_col_busy", busy_cnt, 0);
      chk("full_col_drops", n_drops - d0, 0);

      // movement keys during a fall
      do_reset();
      cyc(8'h2C); cyc(8'h04); cyc(8'h00); cyc(8'h07); cyc(8'h00);
      chk("fall_keys_TokenX", int'(TokenX), 300);
      wait_idle();
      chk("fall_keys_TokenX_after", int'(TokenX), 300);

      // asynchronous reset in the 10th falling frame
      do_reset();
      cyc(8'h2C);
      repeat (9) cyc(8'h00);
      chk("tenth_fall_TokenY", int'(TokenY), 210);
      d0 = n_drops;
      #2 Reset = 1'b0;
      #1;
      chk("async_TokenY", int'(TokenY), 75);
      chk("async_TokenX", int'(TokenX), 300);
      chk("async_busy", int'(busy), 0);
      chk("async_drop_valid", int'(drop_valid), 0);
      model_reset();
      @(negedge frame_clk);
      Reset = 1'b1;
      cyc(8'h2C); cyc(8'h00); wait_idle();
      chk("after_async_drops", n_drops - d0, 1);

      // random key traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         c = $urandom_range(0, 9);
         if (c <= 2) k = 8'h04;
         else if (c <= 5) k = 8'h07;
         else if (c == 6) k = 8'h2C;
         else if (c <= 8) k = 8'h00;
         else k = 8'($urandom_range(0, 255));
         cyc(k);
      end
      wait_idle();

      // fill the whole board in random column order
      do_reset();
      d0 = n_drops;
      for (int n = 0; n < 60 && !m_full; n++) begin
         do c = $urandom_range(0, COLS - 1); while (m_h[c] >= ROWS);
         for (int g = 0; g < 10 && m_sel != c; g++) begin
            cyc((m_sel > c) ? 8'h04 : 8'h07);
            cyc(8'h00);
         end
         cyc(8'h2C); cyc(8'h00); wait_idle();
      end
      chk("fill_drops", n_drops - d0, 42);
      chk("fill_board_full", int'(board_full), 1);
      d0 = n_drops; busy_cnt = 0;
      cyc(8'h04); cyc(8'h00); cyc(8'h2C); cyc(8'h00); cyc(8'h07);
      repeat (5) begin cyc(8'h00); if (busy) busy_cnt++; end
      chk("full_busy", busy_cnt, 0);
      chk("full_drops", n_drops - d0, 0);
      chk("full_still", int'(board_full), 1);

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
